// File: rtl/otter_intr_pkg.sv
// Shared definitions for the OTTER interrupt controller: FSM states,
// register offsets within the IOBUS window and the default base address.
package otter_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP
  } intr_state_e;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h1100_E000;

  localparam logic [31:0] OFF_ENABLE  = 32'h00;
  localparam logic [31:0] OFF_PENDING = 32'h04;
  localparam logic [31:0] OFF_ID      = 32'h08;
  localparam logic [31:0] OFF_EOI     = 32'h0C;
  localparam logic [31:0] OFF_SWTRIG  = 32'h10;

  // Index of the lowest set bit; index 0 wins. Returns 0 for an empty vector.
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// MCU IOBUS slice seen by the interrupt controller: address, write strobe,
// write data, and the combinational read data / hit returned by the slave.
interface intr_ctrl_if;
  logic [31:0] io_addr;
  logic        io_wr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_hit;

  modport master (output io_addr, io_wr, io_wdata, input  io_rdata, io_hit);
  modport slave  (input  io_addr, io_wr, io_wdata, output io_rdata, io_hit);
endinterface

// File: rtl/intr_sync_edge.sv
// One interrupt source: 2-flop synchronizer followed by a rising-edge detector.
// Edges are suppressed until the pipeline holds post-reset samples only.
module intr_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic       sync1, sync2, prev;
  logic [2:0] arm;

  // NOTE: state flops use non-blocking assignments under an async reset so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      arm   <= 3'b000;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
      arm   <= {arm[1:0], 1'b1};
    end
  end

  // An input held high across reset release would otherwise look like 0->1.
  assign rise = sync2 & ~prev & arm[2];

endmodule

// File: rtl/intr_ctrl.sv
// Single-line interrupt controller on the OTTER IOBUS: N synchronized edge
// sources, enable/pending registers, fixed priority and an EOI handshake.
module intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int          N         = 4,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  src_irq,
  intr_ctrl_if.slave    bus,
  output logic          intr_out
);

  logic [N-1:0] enable_q, pending_q, edge_det;
  logic [N-1:0] w1c_mask, sw_set, eoi_clr;
  logic [2:0]   act_id_q, act_id_d;
  intr_state_e  state_q, state_d;

  for (genvar g = 0; g < N; g++) begin : g_src
    intr_sync_edge u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (src_irq[g]),
      .rise     (edge_det[g])
    );
  end

  logic [31:0] off;
  logic sel_enable, sel_pending, sel_id, sel_eoi, sel_swtrig;
  logic wr_enable, wr_eoi;

  assign off         = bus.io_addr - BASE_ADDR;
  assign sel_enable  = (off == OFF_ENABLE);
  assign sel_pending = (off == OFF_PENDING);
  assign sel_id      = (off == OFF_ID);
  assign sel_eoi     = (off == OFF_EOI);
  assign sel_swtrig  = (off == OFF_SWTRIG);
  assign bus.io_hit  = sel_enable | sel_pending | sel_id | sel_eoi | sel_swtrig;

  assign wr_enable = bus.io_wr & sel_enable;
  assign wr_eoi    = bus.io_wr & sel_eoi;
  assign w1c_mask  = (bus.io_wr & sel_pending) ? bus.io_wdata[N-1:0] : '0;
  assign sw_set    = (bus.io_wr & sel_swtrig)  ? bus.io_wdata[N-1:0] : '0;

  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < N; i++) begin
      eoi_clr[i] = wr_eoi && (state_q == ST_ACTIVE) && (act_id_q == 3'(i));
    end
  end

  logic [N-1:0] req;
  assign req = pending_q & enable_q;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    act_id_d = act_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_ACTIVE;
          act_id_d = lowest_set(8'(req));
        end
      end
      ST_ACTIVE: if (wr_eoi) state_d = ST_GAP;
      ST_GAP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      act_id_q  <= 3'd0;
      intr_out  <= 1'b0;
      enable_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q  <= state_d;
      act_id_q <= act_id_d;
      intr_out <= (state_d == ST_ACTIVE);
      if (wr_enable) enable_q <= bus.io_wdata[N-1:0];
      // Clears are applied before sets so a colliding set always survives.
      pending_q <= (pending_q & ~w1c_mask & ~eoi_clr) | edge_det | sw_set;
    end
  end

  always_comb begin
    bus.io_rdata = '0;
    if (sel_enable)  bus.io_rdata[N-1:0] = enable_q;
    if (sel_pending) bus.io_rdata[N-1:0] = pending_q;
    if (sel_id && state_q == ST_ACTIVE) begin
      bus.io_rdata[31]  = 1'b1;
      bus.io_rdata[2:0] = act_id_q;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a model.
module tb_intr_ctrl;

  localparam logic [31:0] BASE = 32'h1100_E000;
  localparam logic [31:0] A_EN = 32'h00, A_PND = 32'h04, A_ID = 32'h08,
                          A_EOI = 32'h0C, A_SW = 32'h10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] src_irq = 4'b0000;
  logic       intr_out;
  int         n_checks = 0;
  int         n_errors = 0;

  intr_ctrl_if bus ();

  intr_ctrl #(.N(4), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_irq  (src_irq),
    .bus      (bus),
    .intr_out (intr_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_en = '0, m_pend = '0;
  logic       m_active = 1'b0, m_gap = 1'b0;
  int         m_act = 0;
  int         m_cnt = 0;             // edges seen since reset release, saturating at 3
  logic [3:0] h1 = '0, h2 = '0, h3 = '0;  // src samples at the last three edges

  function automatic int first_one(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  logic [3:0] m_rise, m_w1c, m_sw, m_eoi_clr;
  logic       w_en, w_eoi;
  assign w_en      = bus.io_wr && (bus.io_addr == BASE + A_EN);
  assign w_eoi     = bus.io_wr && (bus.io_addr == BASE + A_EOI);
  assign m_w1c     = (bus.io_wr && bus.io_addr == BASE + A_PND) ? bus.io_wdata[3:0] : 4'b0;
  assign m_sw      = (bus.io_wr && bus.io_addr == BASE + A_SW)  ? bus.io_wdata[3:0] : 4'b0;
  assign m_rise    = (m_cnt >= 3) ? (h2 & ~h3) : 4'b0;
  assign m_eoi_clr = (m_active && w_eoi) ? (4'b0001 << m_act) : 4'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en <= '0; m_pend <= '0; m_active <= 1'b0; m_gap <= 1'b0; m_act <= 0;
      m_cnt <= 0; h1 <= '0; h2 <= '0; h3 <= '0;
    end else begin
      m_pend <= (m_pend & ~m_w1c & ~m_eoi_clr) | m_rise | m_sw;
      if (w_en) m_en <= bus.io_wdata[3:0];
      if (m_active) begin
        if (w_eoi) begin m_active <= 1'b0; m_gap <= 1'b1; end
      end else if (m_gap) begin
        m_gap <= 1'b0;
      end else if ((m_pend & m_en) != 4'b0) begin
        m_active <= 1'b1;
        m_act    <= first_one(m_pend & m_en);
      end
      m_cnt <= (m_cnt < 3) ? m_cnt + 1 : m_cnt;
      h3 <= h2; h2 <= h1; h1 <= src_irq;
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    case (a - BASE)
      A_EN:    return {28'b0, m_en};
      A_PND:   return {28'b0, m_pend};
      A_ID:    return m_active ? (32'h8000_0000 | 32'(m_act)) : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_hit(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return (o == A_EN) || (o == A_PND) || (o == A_ID) || (o == A_EOI) || (o == A_SW);
  endfunction

  always @(negedge clk) begin
    check("cyc_intr_out", {31'b0, intr_out}, {31'b0, m_active});
    check("cyc_io_hit",   {31'b0, bus.io_hit}, {31'b0, exp_hit(bus.io_addr)});
    check("cyc_io_rdata", bus.io_rdata, exp_rdata(bus.io_addr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [31:0] o, input logic [31:0] d);
    bus.io_addr = BASE + o; bus.io_wdata = d; bus.io_wr = 1'b1;
    tick();
    bus.io_wr = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] o, input logic [31:0] exp);
    bus.io_addr = BASE + o;
    #1;
    check(name, bus.io_rdata, exp);
  endtask

  task automatic chk_intr(input string name, input logic exp);
    check(name, {31'b0, intr_out}, {31'b0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.io_addr = BASE; bus.io_wr = 1'b0; bus.io_wdata = '0;
    rst_n = 1'b0;
    repeat (3) tick();

    // Reset state
    chk_intr("reset_intr", 1'b0);
    read_check("reset_enable", A_EN, 32'h0);
    read_check("reset_id", A_ID, 32'h0);
    rst_n = 1'b1;
    repeat (4) tick();

    // Hardware edge, latency and EOI
    bus_write(A_EN, 32'hF);
    src_irq[2] = 1'b1;
    repeat (3) tick();
    chk_intr("lat_before_4", 1'b0);
    tick();
    chk_intr("lat_at_4", 1'b1);
    src_irq[2] = 1'b0;
    read_check("id_src2", A_ID, 32'h8000_0002);
    bus_write(A_EOI, 32'h0);
    chk_intr("eoi_gap_low", 1'b0);
    tick();
    read_check("pending_clear", A_PND, 32'h0);
    chk_intr("idle_low", 1'b0);

    // Software trigger with priority ordering
    bus_write(A_SW, 32'b1010);
    tick();
    chk_intr("sw_active", 1'b1);
    read_check("sw_id1", A_ID, 32'h8000_0001);
    bus_write(A_EOI, 32'h0);
    chk_intr("sw_gap", 1'b0);
    tick();
    chk_intr("sw_idle", 1'b0);
    tick();
    chk_intr("sw_reassert", 1'b1);
    read_check("sw_id3", A_ID, 32'h8000_0003);
    bus_write(A_EOI, 32'h0);
    repeat (2) tick();

    // Disabled source stays pending, fires once enabled
    bus_write(A_EN, 32'h0);
    src_irq[0] = 1'b1;
    repeat (4) tick();
    read_check("dis_pending", A_PND, 32'h1);
    chk_intr("dis_quiet", 1'b0);
    bus_write(A_EN, 32'h1);
    chk_intr("en_edge1", 1'b0);
    tick();
    chk_intr("en_edge2", 1'b1);
    src_irq[0] = 1'b0;
    bus_write(A_EOI, 32'h0);
    repeat (2) tick();

    // EOI colliding with a new edge on the active source
    bus_write(A_EN, 32'hF);
    bus_write(A_SW, 32'b0010);
    tick();
    read_check("col_id1", A_ID, 32'h8000_0001);
    src_irq[1] = 1'b1;
    repeat (2) tick();
    bus_write(A_EOI, 32'h0);
    read_check("col_pending", A_PND, 32'h2);
    chk_intr("col_gap", 1'b0);
    tick();
    tick();
    chk_intr("col_reassert", 1'b1);
    src_irq[1] = 1'b0;
    bus_write(A_EOI, 32'h0);
    repeat (2) tick();

    // Reset during ACTIVE, source held high across release
    bus_write(A_SW, 32'b0001);
    tick();
    chk_intr("rst_pre_active", 1'b1);
    src_irq = 4'b0100;
    rst_n = 1'b0;
    #1;
    chk_intr("rst_async_drop", 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus_write(A_EN, 32'hF);
    repeat (8) tick();
    chk_intr("rst_no_edge", 1'b0);
    read_check("rst_no_pending", A_PND, 32'h0);
    src_irq = 4'b0000;
    repeat (4) tick();

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      int op;
      logic [3:0] flip;
      flip = 4'b0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
      src_irq = src_irq ^ flip;
      op = $urandom_range(0, 11);
      bus.io_wdata = $urandom();
      bus.io_wr = 1'b0;
      case (op)
        0, 1: begin bus.io_addr = BASE + A_EN;  bus.io_wr = 1'b1; end
        2:    begin bus.io_addr = BASE + A_PND; bus.io_wr = 1'b1; end
        3:    begin bus.io_addr = BASE + A_SW;  bus.io_wr = 1'b1;
                    bus.io_wdata[3:0] = bus.io_wdata[3:0] & bus.io_wdata[7:4]; end
        4, 5: begin bus.io_addr = BASE + A_EOI; bus.io_wr = 1'b1; end
        6:    bus.io_addr = BASE + 32'h14;
        7:    bus.io_addr = $urandom();
        default: bus.io_addr = BASE + 32'(4 * $urandom_range(0, 4));
      endcase
      tick();
    end
    bus.io_wr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter N, default 4: number of interrupt sources, legal range 1..8.
REQ-002 Parameter BASE_ADDR, default 32'h1100E000: IOBUS base address of the register window.
REQ-003 clk  in  1  single clock, shared with MCU IOBUS, rising-edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 src_irq  in  N  raw interrupt requests, possibly asynchronous (buttons, timer_counter tc_intr).
REQ-006 io_addr  in  32  IOBUS address.
REQ-007 io_wr  in  1  IOBUS write strobe.
REQ-008 io_wdata  in  32  IOBUS write data.
REQ-009 io_rdata  out  32  read data for the addressed register; 0 when no hit.
REQ-010 io_hit  out  1  io_addr falls in the register window; the wrapper uses it to select io_rdata.
REQ-011 intr_out  out  1  single interrupt line to the MCU INTR input.

Function
REQ-012 Register map: BASE+0x0 ENABLE (RW, N bits); +0x4 PENDING (R; W1C); +0x8 ID (RO); +0xC EOI (WO); +0x10 SWTRIG (WO, write-1-to-set pending).
REQ-013 io_rdata and io_hit: combinational from io_addr; WO offsets read 0; unused upper bits read 0.
REQ-014 Each src_irq bit: 2-flop synchronizer, then rising-edge detect; a detected edge sets PENDING[i] on the next clk edge.
REQ-015 Set-wins rule: a same-cycle edge, SWTRIG set, or EOI clear targeting the same PENDING bit leaves it set; W1C collisions resolve the same way.
REQ-016 FSM states: IDLE, ACTIVE, GAP.
REQ-017 IDLE -> ACTIVE when (PENDING & ENABLE) != 0; latch act_id = lowest set index (index 0 has highest priority).
REQ-018 ACTIVE: intr_out = 1; ID reads {bit31 = 1, bits[2:0] = act_id}; the state holds until any write to EOI.
REQ-019 An EOI write in ACTIVE clears PENDING[act_id] (subject to REQ-015); next state is GAP.
REQ-020 GAP: intr_out = 0 for exactly 1 cycle, then IDLE; arbitration resumes in IDLE.
REQ-021 intr_out is registered: high only in ACTIVE, first high the cycle after IDLE is left.
REQ-022 Latency: a src_irq rising edge to intr_out high takes 4 clk edges when idle and enabled (sync 2, edge/pending 1, FSM 1).
REQ-023 An EOI write in IDLE or GAP is ignored with no side effects.
REQ-024 Clearing ENABLE[act_id] or W1C of PENDING[act_id] while ACTIVE does not drop intr_out; only EOI ends ACTIVE.
REQ-025 A pending but disabled source stays pending; it fires when later enabled.
REQ-026 In ID, bit31 = 0 and the id field = 0 when not ACTIVE.

Reset
REQ-027 On rst_n low (asynchronous): ENABLE = 0, PENDING = 0, synchronizer and edge flops = 0, act_id = 0, state = IDLE, intr_out = 0.
REQ-028 Reset mid-ACTIVE drops intr_out asynchronously; a src_irq held high through reset release does not generate an edge.

Structure
REQ-029 Package otter_intr_pkg holds the FSM state enum, register offset constants and the default BASE_ADDR.
REQ-030 Sub-module intr_sync_edge (2-flop synchronizer plus rising-edge detect, 1 bit) is instantiated N times.

Verification
REQ-031 Reset with src_irq = 4'b0000 -> all outputs 0; ENABLE read = 0; ID read = 0.
REQ-032 ENABLE = 4'hF; pulse src_irq[2] -> intr_out high 4 edges later; ID = 32'h80000002; EOI -> 1-cycle low, PENDING = 0.
REQ-033 ENABLE = 4'hF; SWTRIG = 4'b1010 -> ID = 32'h80000001; after EOI and the GAP cycle, re-asserts with ID = 32'h80000003.
REQ-034 ENABLE = 0; src_irq[0] edge -> PENDING = 4'b0001 and intr_out stays 0; ENABLE = 1 -> intr_out high 2 edges later.
REQ-035 EOI write and src_irq[1] edge landing in the same cycle as ACTIVE on id 1 -> PENDING[1] stays 1; intr_out re-asserts after GAP.
REQ-036 rst_n low during ACTIVE -> intr_out low immediately; src_irq held at 4'b0100 across release -> no interrupt.
